qpd_capture_window: RTL

//   Downstream of the quarter-period-delay trigger stage. Each one-cycle trigger pulse opens a

---
 rtl/qpd_capture_window.sv | 102 ++++++++++
 1 files changed

// File: rtl/qpd_capture_window.sv
// Capture window behind the quarter-period-delay trigger: buffers capture_len ADC samples per
// trigger in a FIFO and streams them out on valid/ready, tagging the final sample of each window.
module qpd_capture_window #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 64
) (
   input  logic                  sclock,
   input  logic                  rst,
   input  logic                  trigger,
   input  logic [7:0]            capture_len,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  overflow,
   output logic [7:0]            missed_triggers
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StCapture, StFlush} state_e;

   state_e            state_q, state_d;
   logic [8:0]        remaining_q, remaining_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        missed_q, missed_d;
   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH:0] mem_q [DEPTH];

   logic empty, full, wr_en, rd_en;
   logic [DATA_WIDTH:0] head;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_en = (state_q == StCapture) && sample_valid && !full;
   assign rd_en = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      overflow_d  = overflow_q;
      missed_d    = missed_q;
      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               state_d     = StCapture;
               remaining_d = (capture_len == 8'd0) ? 9'd256 : {1'b0, capture_len};
               overflow_d  = 1'b0;
            end
         end
         StCapture: begin
            // Dropped samples still consume window length so the window closes on time.
            if (sample_valid) begin
               remaining_d = remaining_q - 9'd1;
               if (full) overflow_d = 1'b1;
               if (remaining_q == 9'd1) state_d = StFlush;
            end
         end
         StFlush: begin
            if (empty) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (trigger && (state_q != StIdle) && (missed_q != 8'hFF)) missed_d = missed_q + 8'd1;
   end

   always_ff @(posedge sclock or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         remaining_q <= 9'd0;
         overflow_q  <= 1'b0;
         missed_q    <= 8'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         overflow_q  <= overflow_d;
         missed_q    <= missed_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (rd_en) rd_ptr_q <= rd_ptr_q + PtrOne;
      end
   end

   // Storage needs no reset; outputs are gated by the pointer-derived valid.
   always_ff @(posedge sclock) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {remaining_q == 9'd1, sample_data};
   end

   assign head            = mem_q[rd_ptr_q[AW-1:0]];
   assign out_valid       = !empty;
   assign out_data        = out_valid ? head[DATA_WIDTH-1:0] : '0;
   assign out_last        = out_valid & head[DATA_WIDTH];
   assign busy            = (state_q != StIdle);
   assign overflow        = overflow_q;
   assign missed_triggers = missed_q;

endmodule
